seg7_capture_decoder: RTL and testbench

- Inverse of the team's hex-to-7-segment transcoder. Captures a multiplexed, active-low 7-segment display bus from an external board or a loopback pin pair.
- Filters glitches and decodes each digit's glyph back to a 4-bit hex nibble. Holds a per-digit result register with status flags.
- Used in the PS/2 / display test path to self-check what the display driver emits.

---
 rtl/seg7_capture_decoder_if.sv | 27 ++
 rtl/seg7_capture_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_decoder_if.sv
// Pin-side and result-side signals of the 7-segment capture decoder.
// The master modport is the environment (drives the display pins, observes
// decoded results); the slave modport is the decoder itself.
interface seg7_capture_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   update_digit;
    logic                    err_pattern;
    logic                    err_anode;

    modport master (
        output seg_in, an_in,
        input  digits_out, digit_valid, digit_blank, update_digit,
               err_pattern, err_anode
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, digit_valid, digit_blank, update_digit,
               err_pattern, err_anode
    );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Captures a multiplexed active-low 7-segment bus, filters glitches with a
// stability window, and decodes each digit's glyph back to a hex nibble.
module seg7_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    seg7_capture_decoder_if.slave     bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [6:0]            r_seg_meta, r_seg_s;
    logic [NUM_DIGITS-1:0] r_an_meta, r_an_s;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_accept;
    logic                  r_err_pattern, r_err_anode;

    logic [NUM_DIGITS-1:0] w_an_low;
    logic                  w_one_hot;
    logic                  w_multi;
    logic [3:0]            w_nibble;
    logic                  w_legal;
    logic                  w_blank_glyph;

    logic [NUM_DIGITS-1:0] w_sel;
    logic [3:0]            w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_valid, w_blank, w_upd;

    // Two-flop synchronizers; idle (all-ones) is the inactive pin state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_meta <= '1;
            r_seg_s    <= '1;
            r_an_meta  <= '1;
            r_an_s     <= '1;
        end else begin
            r_seg_meta <= bus.seg_in;
            r_seg_s    <= r_seg_meta;
            r_an_meta  <= bus.an_in;
            r_an_s     <= r_an_meta;
        end
    end

    // Next stability count: any change of the incoming sample wins over saturation.
    always_comb begin
        w_cnt_next = r_cnt;
        if ({r_an_meta, r_seg_meta} != {r_an_s, r_seg_s}) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt != STABLE_C) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Stability counter; accept is flagged only on the edge the count first reaches the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_accept <= (w_cnt_next == STABLE_C) && (r_cnt != STABLE_C);
        end
    end

    // Anode classification: none, exactly one, or several digits selected.
    always_comb begin
        w_an_low  = ~r_an_s;
        w_one_hot = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
        w_multi   = (w_an_low != '0) && !w_one_hot;
    end

    // Glyph to nibble lookup (active-low segments, g..a).
    always_comb begin
        w_nibble      = 4'h0;
        w_legal       = 1'b1;
        w_blank_glyph = (r_seg_s == 7'b1111111);
        case (r_seg_s)
            7'b1000000: w_nibble = 4'h0;
            7'b1111001: w_nibble = 4'h1;
            7'b0100100: w_nibble = 4'h2;
            7'b0110000: w_nibble = 4'h3;
            7'b0011001: w_nibble = 4'h4;
            7'b0010010: w_nibble = 4'h5;
            7'b0000010: w_nibble = 4'h6;
            7'b1111000: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0010000: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b0000011: w_nibble = 4'hB;
            7'b1000110: w_nibble = 4'hC;
            7'b0100001: w_nibble = 4'hD;
            7'b0000110: w_nibble = 4'hE;
            7'b0001110: w_nibble = 4'hF;
            default:    w_legal  = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_nib;
            logic       r_valid;
            logic       r_blank;
            logic       r_upd;

            assign w_sel[gi] = r_accept && w_one_hot && w_an_low[gi];

            // Per-digit result register, rewritten on every accept addressed to it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_nib   <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b1;
                    r_upd   <= 1'b0;
                end else begin
                    r_upd <= w_sel[gi];
                    if (w_sel[gi]) begin
                        if (w_legal) begin
                            r_nib   <= w_nibble;
                            r_valid <= 1'b1;
                            r_blank <= 1'b0;
                        end else begin
                            r_valid <= 1'b0;
                            r_blank <= w_blank_glyph;
                        end
                    end
                end
            end

            assign w_nib[gi]   = r_nib;
            assign w_valid[gi] = r_valid;
            assign w_blank[gi] = r_blank;
            assign w_upd[gi]   = r_upd;
        end
    endgenerate

    // Error pulses: illegal glyph on a single digit, or several anodes at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pattern <= 1'b0;
            r_err_anode   <= 1'b0;
        end else begin
            r_err_pattern <= r_accept && w_one_hot && !w_legal && !w_blank_glyph;
            r_err_anode   <= r_accept && w_multi;
        end
    end

    // Pack per-digit nibbles onto the flat output bus.
    always_comb begin
        bus.digits_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bus.digits_out[4*i +: 4] = w_nib[i];
        end
    end

    assign bus.digit_valid  = w_valid;
    assign bus.digit_blank  = w_blank;
    assign bus.update_digit = w_upd;
    assign bus.err_pattern  = r_err_pattern;
    assign bus.err_anode    = r_err_anode;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for the 7-segment capture decoder (4 digits, 16-cycle window).
module tb_seg7_capture_decoder;
    logic clk;
    logic rst;

    seg7_capture_decoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] G_2     = 7'b0100100;
    localparam logic [6:0] G_3     = 7'b0110000;
    localparam logic [6:0] G_B     = 7'b0000011;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_F     = 7'b0001110;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_BAD   = 7'b0101010;

    int n_cmp;
    int n_bad;
    int upd_cnt;
    int errp_cnt;
    int erra_cnt;
    int first_upd;
    logic [3:0] upd_seen;

    task automatic clear_counts();
        upd_cnt  = 0;
        errp_cnt = 0;
        erra_cnt = 0;
        upd_seen = 4'b0000;
    endtask

    // Drive the pins now (at a falling edge) and observe n following falling edges.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        first_upd  = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.update_digit != 4'b0000) begin
                upd_cnt  += $countones(bus.update_digit);
                upd_seen |= bus.update_digit;
                if (first_upd == 0) first_upd = i;
            end
            if (bus.err_pattern) errp_cnt++;
            if (bus.err_anode)   erra_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.an_in  = 4'b0000;
        bus.seg_in = 7'b0000000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.digits_out !== 16'h0000) begin
            n_bad++; $display("FAIL reset_digits: got %h want 0000", bus.digits_out);
        end
        n_cmp++;
        if (bus.digit_valid !== 4'b0000) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0000", bus.digit_valid);
        end
        n_cmp++;
        if (bus.digit_blank !== 4'b1111) begin
            n_bad++; $display("FAIL reset_blank: got %b want 1111", bus.digit_blank);
        end
        n_cmp++;
        if ({bus.update_digit, bus.err_pattern, bus.err_anode} !== 6'b0) begin
            n_bad++; $display("FAIL reset_pulses: got upd=%b ep=%b ea=%b want 0",
                              bus.update_digit, bus.err_pattern, bus.err_anode);
        end
        bus.an_in  = 4'b1111;
        bus.seg_in = G_BLANK;
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        hold(4'b1111, G_BLANK, 20);
        n_cmp++;
        if (upd_cnt + errp_cnt + erra_cnt !== 0) begin
            n_bad++; $display("FAIL idle_after_reset: got %0d pulses want 0", upd_cnt + errp_cnt + erra_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_digit();
        clear_counts();
        hold(4'b1110, G_2, 30);
        n_cmp++;
        if (first_upd !== 18) begin
            n_bad++; $display("FAIL single_latency: got update at sample %0d want 18 (edge 17)", first_upd);
        end
        n_cmp++;
        if (upd_cnt !== 1 || upd_seen !== 4'b0001) begin
            n_bad++; $display("FAIL single_pulse: got %0d pulses on %b want 1 on 0001", upd_cnt, upd_seen);
        end
        n_cmp++;
        if (bus.digits_out[3:0] !== 4'h2 || bus.digit_valid[0] !== 1'b1 || bus.digit_blank[0] !== 1'b0) begin
            n_bad++; $display("FAIL single_value: got nib=%h v=%b b=%b want 2 1 0",
                              bus.digits_out[3:0], bus.digit_valid[0], bus.digit_blank[0]);
        end
        hold(4'b1111, G_BLANK, 20);
        $display("test_single_digit done");
    endtask

    task automatic test_glitch();
        clear_counts();
        hold(4'b1110, G_B, 15);
        hold(4'b1110, G_2 ^ 7'b0000001, 3);
        hold(4'b1111, G_BLANK, 20);
        n_cmp++;
        if (upd_cnt !== 0 || bus.digits_out[3:0] !== 4'h2) begin
            n_bad++; $display("FAIL glitch_15: got %0d pulses nib=%h want 0 pulses nib=2", upd_cnt, bus.digits_out[3:0]);
        end
        clear_counts();
        hold(4'b1110, G_B, 16);
        hold(4'b1111, G_BLANK, 20);
        n_cmp++;
        if (upd_cnt !== 1 || bus.digits_out[3:0] !== 4'hB) begin
            n_bad++; $display("FAIL glitch_16: got %0d pulses nib=%h want 1 pulse nib=B", upd_cnt, bus.digits_out[3:0]);
        end
        $display("test_glitch done");
    endtask

    task automatic test_scan();
        logic [6:0] glyphs [4];
        int blank_upd;
        glyphs[0] = G_B; glyphs[1] = G_E; glyphs[2] = G_E; glyphs[3] = G_F;
        blank_upd = 0;
        clear_counts();
        for (int d = 0; d < 4; d++) begin
            logic [3:0] an;
            an = 4'b1111;
            an[d] = 1'b0;
            hold(an, glyphs[d], 32);
            blank_upd -= upd_cnt;
            hold(4'b1111, G_BLANK, 8);
            blank_upd += upd_cnt;
        end
        n_cmp++;
        if (bus.digits_out !== 16'hFEEB) begin
            n_bad++; $display("FAIL scan_digits: got %h want FEEB", bus.digits_out);
        end
        n_cmp++;
        if (bus.digit_valid !== 4'b1111 || bus.digit_blank !== 4'b0000) begin
            n_bad++; $display("FAIL scan_flags: got v=%b b=%b want 1111 0000", bus.digit_valid, bus.digit_blank);
        end
        n_cmp++;
        if (upd_cnt !== 4 || upd_seen !== 4'b1111) begin
            n_bad++; $display("FAIL scan_pulses: got %0d on %b want 4 on 1111", upd_cnt, upd_seen);
        end
        n_cmp++;
        if (blank_upd !== 0) begin
            n_bad++; $display("FAIL scan_blanking: got %0d pulses during blanking want 0", blank_upd);
        end
        $display("test_scan done");
    endtask

    task automatic test_errors();
        clear_counts();
        hold(4'b1101, G_BAD, 30);
        n_cmp++;
        if (errp_cnt !== 1 || upd_cnt !== 1 || upd_seen !== 4'b0010) begin
            n_bad++; $display("FAIL err_pattern: got ep=%0d upd=%0d on %b want 1 1 0010", errp_cnt, upd_cnt, upd_seen);
        end
        n_cmp++;
        if (bus.digit_valid[1] !== 1'b0 || bus.digit_blank[1] !== 1'b0 || bus.digits_out[7:4] !== 4'hE) begin
            n_bad++; $display("FAIL err_pattern_state: got v=%b b=%b nib=%h want 0 0 E",
                              bus.digit_valid[1], bus.digit_blank[1], bus.digits_out[7:4]);
        end
        hold(4'b1111, G_BLANK, 8);
        clear_counts();
        hold(4'b1011, G_BLANK, 30);
        n_cmp++;
        if (bus.digit_blank[2] !== 1'b1 || bus.digit_valid[2] !== 1'b0 || bus.digits_out[11:8] !== 4'hE
            || upd_cnt !== 1 || errp_cnt !== 0) begin
            n_bad++; $display("FAIL blank_glyph: got b=%b v=%b nib=%h upd=%0d ep=%0d want 1 0 E 1 0",
                              bus.digit_blank[2], bus.digit_valid[2], bus.digits_out[11:8], upd_cnt, errp_cnt);
        end
        hold(4'b1111, G_BLANK, 8);
        clear_counts();
        hold(4'b1100, 7'b0000000, 30);
        n_cmp++;
        if (erra_cnt !== 1 || upd_cnt !== 0 || bus.digits_out !== 16'hFEEB) begin
            n_bad++; $display("FAIL err_anode: got ea=%0d upd=%0d digits=%h want 1 0 FEEB", erra_cnt, upd_cnt, bus.digits_out);
        end
        hold(4'b1111, G_BLANK, 8);
        $display("test_errors done");
    endtask

    task automatic test_reset_mid();
        clear_counts();
        hold(4'b0111, G_3, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(4'b0111, G_3, 30);
        n_cmp++;
        if (first_upd !== 18 || upd_cnt !== 1) begin
            n_bad++; $display("FAIL reset_mid_latency: got update at sample %0d (%0d pulses) want 18 (1)", first_upd, upd_cnt);
        end
        n_cmp++;
        if (bus.digits_out !== 16'h3000 || bus.digit_valid !== 4'b1000 || bus.digit_blank !== 4'b0111) begin
            n_bad++; $display("FAIL reset_mid_state: got %h v=%b b=%b want 3000 1000 0111",
                              bus.digits_out, bus.digit_valid, bus.digit_blank);
        end
        hold(4'b1111, G_BLANK, 8);
        $display("test_reset_mid done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.an_in  = 4'b1111;
        bus.seg_in = G_BLANK;
        @(negedge clk);
        test_reset();
        test_single_digit();
        test_glitch();
        test_scan();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
